// File: rtl/mem_access_if.sv
// Data-bus interface between the MEM stage (master) and data memory (slave).
// Requests are registered by the master; ack and rdata come back in the same cycle.
interface mem_access_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                req;
  logic                we;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W/8-1:0] sel;
  logic [DATA_W-1:0]   wdata;
  logic                ack;
  logic [DATA_W-1:0]   rdata;

  modport master (output req, we, addr, sel, wdata, input ack, rdata);
  modport slave  (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: big-endian loads/stores over a req/ack data bus with pipeline stall.
// Optional misaligned-access exception enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              whilo_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic [7:0]        aluop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] reg2_i,
  output logic [4:0]        mem_wd,
  output logic              mem_wreg,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_whilo,
  output logic [DATA_W-1:0] mem_hi,
  output logic [DATA_W-1:0] mem_lo,
  output logic              stallreq,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              excp_align,
  output logic [ADDR_W-1:0] excp_badaddr,
`endif
  mem_access_if.master      dbus
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t            state, state_next;
  size_t             acc_size;
  logic              is_load, is_store, is_sign, is_mem;
  logic              start_acc, end_acc, stall_c;
  logic [1:0]        addr_lo;
  logic [3:0]        sel_c;
  logic [DATA_W-1:0] wdata_c, load_c, rdata_q;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
`ifdef MEM_ALIGN_CHECK_EN
  logic              misaligned, misalign_hit, excp_q;
`endif

  assign addr_lo = mem_addr_i[1:0];
  assign is_mem  = is_load | is_store;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_sign  = 1'b0;
    acc_size = SZ_WORD;
    case (aluop_i)
      EXE_LB_OP:  begin is_load = 1'b1; is_sign = 1'b1; acc_size = SZ_BYTE; end
      EXE_LBU_OP: begin is_load = 1'b1; acc_size = SZ_BYTE; end
      EXE_LH_OP:  begin is_load = 1'b1; is_sign = 1'b1; acc_size = SZ_HALF; end
      EXE_LHU_OP: begin is_load = 1'b1; acc_size = SZ_HALF; end
      EXE_LW_OP:  is_load = 1'b1;
      EXE_SB_OP:  begin is_store = 1'b1; acc_size = SZ_BYTE; end
      EXE_SH_OP:  begin is_store = 1'b1; acc_size = SZ_HALF; end
      EXE_SW_OP:  is_store = 1'b1;
      default: ;
    endcase
  end

  // Big-endian lanes: address offset 0 is the most significant byte.
  always_comb begin
    sel_c     = 4'b1111;
    wdata_c   = reg2_i;
    byte_lane = dbus.rdata[31:24];
    half_lane = dbus.rdata[31:16];
    load_c    = dbus.rdata;
    case (acc_size)
      SZ_BYTE: begin
        sel_c   = 4'b1000 >> addr_lo;
        wdata_c = {4{reg2_i[7:0]}};
        case (addr_lo)
          2'd0:    byte_lane = dbus.rdata[31:24];
          2'd1:    byte_lane = dbus.rdata[23:16];
          2'd2:    byte_lane = dbus.rdata[15:8];
          default: byte_lane = dbus.rdata[7:0];
        endcase
        load_c = is_sign ? {{24{byte_lane[7]}}, byte_lane} : {24'b0, byte_lane};
      end
      SZ_HALF: begin
        sel_c     = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata_c   = {2{reg2_i[15:0]}};
        half_lane = addr_lo[1] ? dbus.rdata[15:0] : dbus.rdata[31:16];
        load_c    = is_sign ? {{16{half_lane[15]}}, half_lane} : {16'b0, half_lane};
      end
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ((acc_size == SZ_HALF) && addr_lo[0]) ||
                      ((acc_size == SZ_WORD) && (addr_lo != 2'd0));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_acc  = 1'b0;
    end_acc    = 1'b0;
    stall_c    = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misalign_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (is_mem) begin
          stall_c = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
          if (misaligned) begin
            misalign_hit = 1'b1;
            state_next   = DONE;
          end else begin
            start_acc  = 1'b1;
            state_next = BUSY;
          end
`else
          start_acc  = 1'b1;
          state_next = BUSY;
`endif
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (dbus.ack) begin
          end_acc    = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus fields are loaded once per access and held until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbus.req   <= 1'b0;
      dbus.we    <= 1'b0;
      dbus.addr  <= '0;
      dbus.sel   <= '0;
      dbus.wdata <= '0;
      rdata_q    <= '0;
    end else begin
      if (start_acc) begin
        dbus.req   <= 1'b1;
        dbus.we    <= is_store;
        dbus.addr  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
        dbus.sel   <= sel_c;
        dbus.wdata <= wdata_c;
      end
      if (end_acc) begin
        dbus.req <= 1'b0;
        rdata_q  <= load_c;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) excp_q <= 1'b0;
    else     excp_q <= misalign_hit;
  end
`endif

  always_comb begin
    mem_wd    = wd_i;
    mem_wreg  = wreg_i;
    mem_whilo = whilo_i;
    mem_hi    = hi_i;
    mem_lo    = lo_i;
    mem_wdata = ((state == DONE) && is_load) ? rdata_q : wdata_i;
    stallreq  = stall_c;
`ifdef MEM_ALIGN_CHECK_EN
    excp_align   = (state == DONE) && excp_q;
    excp_badaddr = excp_align ? mem_addr_i : '0;
    if (excp_align) begin
      mem_wreg  = 1'b0;
      mem_wdata = wdata_i;
    end
`endif
    if (rst) begin
      mem_wd    = 5'd0;
      mem_wreg  = 1'b0;
      mem_wdata = '0;
      mem_whilo = 1'b0;
      mem_hi    = '0;
      mem_lo    = '0;
      stallreq  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      excp_align   = 1'b0;
      excp_badaddr = '0;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access; MEM_ALIGN_CHECK_EN adds the misalignment case.
`timescale 1ns/1ps
module tb_mem_access;

  localparam logic [7:0] EXE_LB_OP   = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP  = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP   = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP  = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP   = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP   = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP   = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP   = 8'b1110_1011;
  localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic        whilo_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] reg2_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        stallreq;
`ifdef MEM_ALIGN_CHECK_EN
  logic        excp_align;
  logic [31:0] excp_badaddr;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .whilo_i      (whilo_i),
    .hi_i         (hi_i),
    .lo_i         (lo_i),
    .aluop_i      (aluop_i),
    .mem_addr_i   (mem_addr_i),
    .reg2_i       (reg2_i),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_whilo    (mem_whilo),
    .mem_hi       (mem_hi),
    .mem_lo       (mem_lo),
    .stallreq     (stallreq),
`ifdef MEM_ALIGN_CHECK_EN
    .excp_align   (excp_align),
    .excp_badaddr (excp_badaddr),
`endif
    .dbus         (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                               input logic [31:0] wdata, input logic [4:0] wd, input logic wreg);
    @(posedge clk);
    #1;
    aluop_i    = op;
    mem_addr_i = addr;
    reg2_i     = reg2;
    wdata_i    = wdata;
    wd_i       = wd;
    wreg_i     = wreg;
  endtask

  // Acts as the memory: acks in the busy-th cycle that req is seen, returns at the first unstalled cycle.
  task automatic runAccess(input string tag, input int busy, input logic [31:0] rd,
                           input logic [31:0] e_we, input logic [31:0] e_addr, input logic [31:0] e_sel,
                           input logic [31:0] e_wdata, input int e_stall);
    int   stall    = 0;
    int   nreq     = 0;
    int   unstable = 0;
    logic done     = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (stallreq) stall++;
      if (bus.req) begin
        nreq++;
        if (nreq == 1) begin
          checkOutput({tag, "_we"},    32'(bus.we),  e_we);
          checkOutput({tag, "_addr"},  bus.addr,     e_addr);
          checkOutput({tag, "_sel"},   32'(bus.sel), e_sel);
          checkOutput({tag, "_wdata"}, bus.wdata,    e_wdata);
        end else if (bus.we !== e_we[0] || bus.addr !== e_addr ||
                     bus.sel !== e_sel[3:0] || bus.wdata !== e_wdata) begin
          unstable++;
        end
      end
      if (!stallreq) begin
        done    = 1'b1;
        bus.ack = 1'b0;
      end else begin
        bus.ack   = bus.req && (nreq == busy);
        bus.rdata = rd;
      end
    end
    checkOutput({tag, "_done"},     32'(done),    32'd1);
    checkOutput({tag, "_stall"},    stall,        e_stall);
    checkOutput({tag, "_stable"},   unstable,     32'd0);
    checkOutput({tag, "_req_drop"}, 32'(bus.req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic found;
    rst        = 1'b1;
    bus.ack    = 1'b0;
    bus.rdata  = 32'h0;
    aluop_i    = EXE_LW_OP;
    mem_addr_i = 32'h100;
    reg2_i     = 32'h0;
    wd_i       = 5'd5;
    wreg_i     = 1'b1;
    wdata_i    = 32'h7;
    whilo_i    = 1'b1;
    hi_i       = 32'h1111_2222;
    lo_i       = 32'h3333_4444;

    @(negedge clk);
    checkOutput("rst_req",       32'(bus.req),   32'd0);
    checkOutput("rst_we",        32'(bus.we),    32'd0);
    checkOutput("rst_addr",      bus.addr,       32'd0);
    checkOutput("rst_sel",       32'(bus.sel),   32'd0);
    checkOutput("rst_wdata",     bus.wdata,      32'd0);
    checkOutput("rst_stall",     32'(stallreq),  32'd0);
    checkOutput("rst_mem_wd",    32'(mem_wd),    32'd0);
    checkOutput("rst_mem_wreg",  32'(mem_wreg),  32'd0);
    checkOutput("rst_mem_wdata", mem_wdata,      32'd0);
    checkOutput("rst_mem_whilo", 32'(mem_whilo), 32'd0);
    checkOutput("rst_mem_hi",    mem_hi,         32'd0);
    checkOutput("rst_mem_lo",    mem_lo,         32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    checkOutput("rst_excp_align", 32'(excp_align), 32'd0);
    checkOutput("rst_excp_bad",   excp_badaddr,    32'd0);
`endif

    // Pass-through ALU op while leaving reset
    aluop_i = EXE_ADDU_OP;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("addu_stall", 32'(stallreq),  32'd0);
    checkOutput("addu_req",   32'(bus.req),   32'd0);
    checkOutput("addu_wdata", mem_wdata,      32'h7);
    checkOutput("addu_wd",    32'(mem_wd),    32'd5);
    checkOutput("addu_wreg",  32'(mem_wreg),  32'd1);
    checkOutput("addu_whilo", 32'(mem_whilo), 32'd1);
    checkOutput("addu_hi",    mem_hi,         32'h1111_2222);
    checkOutput("addu_lo",    mem_lo,         32'h3333_4444);
    @(negedge clk);
    checkOutput("addu_req_later", 32'(bus.req), 32'd0);

    applyStimulus(EXE_LW_OP, 32'h100, 32'h0, 32'h100, 5'd3, 1'b1);
    runAccess("lw", 1, 32'h1234_5678, 32'd0, 32'h100, 32'hF, 32'h0, 2);
    checkOutput("lw_data", mem_wdata, 32'h1234_5678);

    applyStimulus(EXE_LB_OP, 32'h103, 32'h0, 32'h103, 5'd3, 1'b1);
    runAccess("lb3", 1, 32'h0000_00F0, 32'd0, 32'h100, 32'h1, 32'h0, 2);
    checkOutput("lb3_data", mem_wdata, 32'hFFFF_FFF0);

    applyStimulus(EXE_LBU_OP, 32'h103, 32'h0, 32'h103, 5'd3, 1'b1);
    runAccess("lbu3", 1, 32'h0000_00F0, 32'd0, 32'h100, 32'h1, 32'h0, 2);
    checkOutput("lbu3_data", mem_wdata, 32'h0000_00F0);

    applyStimulus(EXE_LB_OP, 32'h101, 32'h0, 32'h101, 5'd3, 1'b1);
    runAccess("lb1", 1, 32'h00AB_0000, 32'd0, 32'h100, 32'h4, 32'h0, 2);
    checkOutput("lb1_data", mem_wdata, 32'hFFFF_FFAB);

    applyStimulus(EXE_LH_OP, 32'h102, 32'h0, 32'h102, 5'd3, 1'b1);
    runAccess("lh2", 1, 32'h1234_8001, 32'd0, 32'h100, 32'h3, 32'h0, 2);
    checkOutput("lh2_data", mem_wdata, 32'hFFFF_8001);

    applyStimulus(EXE_LHU_OP, 32'h100, 32'h0, 32'h100, 5'd3, 1'b1);
    runAccess("lhu0", 1, 32'h8001_0000, 32'd0, 32'h100, 32'hC, 32'h0, 2);
    checkOutput("lhu0_data", mem_wdata, 32'h0000_8001);

    applyStimulus(EXE_SH_OP, 32'h202, 32'hAAAA_1234, 32'h202, 5'd0, 1'b0);
    runAccess("sh", 4, 32'h0, 32'd1, 32'h200, 32'h3, 32'h1234_1234, 5);
    checkOutput("sh_mem_wdata", mem_wdata,     32'h202);
    checkOutput("sh_mem_wreg",  32'(mem_wreg), 32'd0);

    applyStimulus(EXE_SB_OP, 32'h301, 32'h0000_005A, 32'h301, 5'd0, 1'b0);
    runAccess("sb", 2, 32'h0, 32'd1, 32'h300, 32'h4, 32'h5A5A_5A5A, 3);

    applyStimulus(EXE_SW_OP, 32'h300, 32'hDEAD_BEEF, 32'h300, 5'd0, 1'b0);
    runAccess("sw", 1, 32'h0, 32'd1, 32'h300, 32'hF, 32'hDEAD_BEEF, 2);

    // Reset in the middle of an outstanding access, with ack arriving late
    applyStimulus(EXE_LW_OP, 32'h400, 32'h0, 32'h400, 5'd7, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (bus.req === 1'b1) found = 1'b1;
    end
    checkOutput("rstbusy_req_seen", 32'(found), 32'd1);
    rst       = 1'b1;
    bus.ack   = 1'b1;
    bus.rdata = 32'hBAD0_BAD0;
    #1;
    checkOutput("rstbusy_req",       32'(bus.req),  32'd0);
    checkOutput("rstbusy_addr",      bus.addr,      32'd0);
    checkOutput("rstbusy_sel",       32'(bus.sel),  32'd0);
    checkOutput("rstbusy_stall",     32'(stallreq), 32'd0);
    checkOutput("rstbusy_mem_wd",    32'(mem_wd),   32'd0);
    checkOutput("rstbusy_mem_wreg",  32'(mem_wreg), 32'd0);
    checkOutput("rstbusy_mem_wdata", mem_wdata,     32'd0);
    checkOutput("rstbusy_mem_hi",    mem_hi,        32'd0);
    applyStimulus(EXE_ADDU_OP, 32'h0, 32'h0, 32'h7, 5'd5, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("stale_stall", 32'(stallreq), 32'd0);
    checkOutput("stale_req",   32'(bus.req),  32'd0);
    @(negedge clk);
    checkOutput("stale_req_later", 32'(bus.req), 32'd0);
    checkOutput("stale_wdata",     mem_wdata,    32'h7);
    bus.ack = 1'b0;

    applyStimulus(EXE_LW_OP, 32'h400, 32'h0, 32'h400, 5'd7, 1'b1);
    runAccess("lw_after_rst", 1, 32'hCAFE_F00D, 32'd0, 32'h400, 32'hF, 32'h0, 2);
    checkOutput("lw_after_rst_data", mem_wdata, 32'hCAFE_F00D);

`ifdef MEM_ALIGN_CHECK_EN
    applyStimulus(EXE_LW_OP, 32'h102, 32'h0, 32'h55, 5'd9, 1'b1);
    @(negedge clk);
    checkOutput("mis_idle_stall", 32'(stallreq),   32'd1);
    checkOutput("mis_idle_req",   32'(bus.req),    32'd0);
    checkOutput("mis_idle_excp",  32'(excp_align), 32'd0);
    @(negedge clk);
    checkOutput("mis_done_excp",  32'(excp_align), 32'd1);
    checkOutput("mis_done_bad",   excp_badaddr,    32'h102);
    checkOutput("mis_done_wreg",  32'(mem_wreg),   32'd0);
    checkOutput("mis_done_stall", 32'(stallreq),   32'd0);
    checkOutput("mis_done_req",   32'(bus.req),    32'd0);
    applyStimulus(EXE_ADDU_OP, 32'h0, 32'h0, 32'h7, 5'd5, 1'b1);
    @(negedge clk);
    checkOutput("mis_after_excp", 32'(excp_align), 32'd0);
    checkOutput("mis_after_bad",  excp_badaddr,    32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
